// File: rtl/spi_reg_ctrl_if.sv
// Byte-level handshake between the SPI slave byte engine and the register controller.
// The controller side is "master" (it calls for transmits); the byte engine side is "slave".
interface spi_reg_ctrl_if;
    logic       cs_n;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic       tx_call;
    logic [7:0] tx_data;

    modport master (input cs_n, rx_data, rx_done, tx_done, output tx_call, tx_data);
    modport slave  (output cs_n, rx_data, rx_done, tx_done, input tx_call, tx_data);
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI command/register controller: command byte + data burst per chip-select frame,
// RW control bank at low addresses, RO status window above, auto-incrementing pointer.
module spi_reg_ctrl #(
    parameter int          ADDR_W   = 4,
    parameter int          RW_N     = 8,
    parameter logic [63:0] CTRL_RST = 64'h0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    spi_reg_ctrl_if.master      bus,
    output logic [63:0]         ctrl_regs_o,
    input  logic [63:0]         status_in_i,
    output logic                wr_stb_o,
    output logic [ADDR_W-1:0]   wr_addr_o,
    output logic                err_o
);
    typedef enum logic [2:0] {IDLE, CMD, WR, RD, DROP} state_e;

    localparam logic [ADDR_W:0] RW_LIM = (ADDR_W+1)'(RW_N);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d;
    logic [7:0][7:0]   ctrl_q, ctrl_d, status_b;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_call_q, tx_call_d;
    logic              wr_stb_q, wr_stb_d;
    logic              err_q, err_d;
    logic              armed_q, armed_d;
    logic [ADDR_W-1:0] cmd_addr, nxt_addr;
    logic [7:0]        cmd_byte, nxt_byte;

    function automatic logic [7:0] rd_byte(input logic [ADDR_W-1:0] a,
                                           input logic [7:0][7:0] c,
                                           input logic [7:0][7:0] s);
        if ({1'b0, a} < RW_LIM) return c[a[2:0]];
        return s[3'(a - ADDR_W'(RW_N))];
    endfunction

    assign status_b = status_in_i;
    assign cmd_addr = bus.rx_data[ADDR_W-1:0];
    assign nxt_addr = ptr_q + ADDR_W'(1);
    assign cmd_byte = rd_byte(cmd_addr, ctrl_q, status_b);
    assign nxt_byte = rd_byte(nxt_addr, ctrl_q, status_b);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        ctrl_d    = ctrl_q;
        tx_data_d = tx_data_q;
        tx_call_d = tx_call_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        err_d     = err_q;
        // A command is only accepted after cs_n has been seen high since reset.
        armed_d   = armed_q | bus.cs_n;

        if (bus.cs_n) begin
            state_d   = IDLE;
            tx_call_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (armed_q) state_d = CMD;
                CMD: if (bus.rx_done) begin
                    if (bus.rx_data[6:4] != 3'b000) begin
                        err_d   = 1'b1;
                        state_d = DROP;
                    end else begin
                        ptr_d = cmd_addr;
                        if (bus.rx_data[7]) begin
                            state_d   = RD;
                            tx_data_d = cmd_byte;
                            tx_call_d = 1'b1;
                        end else begin
                            state_d = WR;
                        end
                    end
                end
                WR: if (bus.rx_done) begin
                    ptr_d = nxt_addr;
                    if ({1'b0, ptr_q} < RW_LIM) begin
                        wr_stb_d              = 1'b1;
                        wr_addr_d             = ptr_q;
                        ctrl_d[ptr_q[2:0]]    = bus.rx_data;
                        // Bit 7 of register 0 is a write-1-to-clear strobe for err, never stored.
                        if (ptr_q == '0) begin
                            ctrl_d[0][7] = 1'b0;
                            if (bus.rx_data[7]) err_d = 1'b0;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                RD: if (bus.tx_done) begin
                    ptr_d     = nxt_addr;
                    tx_data_d = nxt_byte;
                end
                DROP:    tx_call_d = 1'b0;
                default: state_d   = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            ctrl_q    <= CTRL_RST;
            tx_data_q <= '0;
            tx_call_q <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            err_q     <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            ctrl_q    <= ctrl_d;
            tx_data_q <= tx_data_d;
            tx_call_q <= tx_call_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            err_q     <= err_d;
            armed_q   <= armed_d;
        end
    end

    assign bus.tx_call  = tx_call_q;
    assign bus.tx_data  = tx_data_q;
    assign ctrl_regs_o  = ctrl_q;
    assign wr_stb_o     = wr_stb_q;
    assign wr_addr_o    = wr_addr_q;
    assign err_o        = err_q;
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: scripted scenarios plus randomized frames
// checked against a byte-array reference model.
module tb_spi_reg_ctrl;
    localparam logic [63:0] RST_VAL = 64'h0807060504030201;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] ctrl_regs, status_in;
    logic        wr_stb, err;
    logic [3:0]  wr_addr;

    spi_reg_ctrl_if bus();

    spi_reg_ctrl #(.ADDR_W(4), .RW_N(8), .CTRL_RST(RST_VAL)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus),
        .ctrl_regs_o(ctrl_regs), .status_in_i(status_in),
        .wr_stb_o(wr_stb), .wr_addr_o(wr_addr), .err_o(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int stb_q[$];

    // wr_stb log: one entry per cycle in which the strobe is high
    always @(negedge clk) if (wr_stb === 1'b1) stb_q.push_back(int'(wr_addr));

    // ---------------- reference model ----------------
    logic [7:0] m_ctrl[8];
    logic       m_err;

    task automatic m_reset();
        logic [63:0] rv;
        rv = RST_VAL;
        for (int i = 0; i < 8; i++) m_ctrl[i] = rv[8*i +: 8];
        m_err = 1'b0;
    endtask

    function automatic logic [63:0] m_pack();
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = m_ctrl[i];
        return r;
    endfunction

    function automatic logic [7:0] m_read(input int a);
        int b;
        b = a % 16;
        if (b < 8) return m_ctrl[b];
        return status_in[8*(b-8) +: 8];
    endfunction

    task automatic m_write(input int a, input logic [7:0] d);
        if (a < 8) begin
            m_ctrl[a] = (a == 0) ? {1'b0, d[6:0]} : d;
            if (a == 0 && d[7]) m_err = 1'b0;
        end else begin
            m_err = 1'b1;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        bus.cs_n = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic end_frame();
        bus.cs_n = 1'b1;
        cyc();
        cyc();
    endtask

    task automatic send_rx(input logic [7:0] b, input logic with_tx);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        bus.tx_done = with_tx;
        cyc();
        bus.rx_done = 1'b0;
        bus.tx_done = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        m_reset();
        n_chk++; if (bus.tx_call !== 1'b0) begin n_fail++; $display("FAIL rst_tx_call got=%b exp=0", bus.tx_call); end
        n_chk++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data got=%h exp=00", bus.tx_data); end
        n_chk++; if (ctrl_regs !== m_pack()) begin n_fail++; $display("FAIL rst_ctrl got=%h exp=%h", ctrl_regs, m_pack()); end
        n_chk++; if (wr_stb !== 1'b0) begin n_fail++; $display("FAIL rst_wr_stb got=%b exp=0", wr_stb); end
        n_chk++; if (wr_addr !== 4'h0) begin n_fail++; $display("FAIL rst_wr_addr got=%h exp=0", wr_addr); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", err); end
        rst = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_read_burst();
        logic [7:0] exp;
        start_frame();
        send_rx(8'h80, 1'b0);
        n_chk++; if (bus.tx_call !== 1'b1) begin n_fail++; $display("FAIL rd_tx_call got=%b exp=1", bus.tx_call); end
        n_chk++; if (bus.tx_data !== 8'h01) begin n_fail++; $display("FAIL rd_byte0 got=%h exp=01", bus.tx_data); end
        repeat (3) cyc();
        n_chk++; if (bus.tx_data !== 8'h01) begin n_fail++; $display("FAIL rd_hold got=%h exp=01", bus.tx_data); end
        for (int k = 1; k <= 3; k++) begin
            send_rx(8'hFF, 1'b1);
            exp = m_read(k);
            n_chk++; if (bus.tx_data !== exp) begin n_fail++; $display("FAIL rd_byte%0d got=%h exp=%h", k, bus.tx_data, exp); end
        end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rd_err got=%b exp=0", err); end
        bus.cs_n = 1'b1;
        cyc();
        n_chk++; if (bus.tx_call !== 1'b0) begin n_fail++; $display("FAIL rd_end_tx_call got=%b exp=0", bus.tx_call); end
        cyc();
    endtask

    task automatic test_write_burst();
        stb_q.delete();
        start_frame();
        send_rx(8'h02, 1'b0);
        send_rx(8'hAA, 1'b0);
        m_write(2, 8'hAA);
        n_chk++; if (wr_stb !== 1'b1 || wr_addr !== 4'd2) begin n_fail++; $display("FAIL wr_stb0 got=%b/%h exp=1/2", wr_stb, wr_addr); end
        n_chk++; if (ctrl_regs !== m_pack()) begin n_fail++; $display("FAIL wr_reg2 got=%h exp=%h", ctrl_regs, m_pack()); end
        cyc();
        n_chk++; if (wr_stb !== 1'b0) begin n_fail++; $display("FAIL wr_stb_single got=%b exp=0", wr_stb); end
        send_rx(8'hBB, 1'b0);
        m_write(3, 8'hBB);
        n_chk++; if (ctrl_regs !== m_pack()) begin n_fail++; $display("FAIL wr_reg3 got=%h exp=%h", ctrl_regs, m_pack()); end
        end_frame();
        n_chk++; if (stb_q.size() != 2) begin n_fail++; $display("FAIL wr_stb_count got=%0d exp=2", stb_q.size()); end
        else begin
            n_chk++; if (stb_q[0] != 2 || stb_q[1] != 3) begin n_fail++; $display("FAIL wr_stb_addrs got=%0d,%0d exp=2,3", stb_q[0], stb_q[1]); end
        end
    endtask

    task automatic test_wrap_ro();
        logic [7:0] exp;
        status_in = {$urandom, $urandom};
        status_in[7:0] = 8'h5A;
        stb_q.delete();
        start_frame();
        send_rx(8'h0F, 1'b0);
        send_rx(8'h11, 1'b0);
        m_write(15, 8'h11);
        n_chk++; if (wr_stb !== 1'b0) begin n_fail++; $display("FAIL ro_wr_stb got=%b exp=0", wr_stb); end
        n_chk++; if (err !== m_err) begin n_fail++; $display("FAIL ro_err got=%b exp=%b", err, m_err); end
        send_rx(8'h22, 1'b0);
        m_write(0, 8'h22);
        n_chk++; if (wr_stb !== 1'b1 || wr_addr !== 4'd0) begin n_fail++; $display("FAIL wrap_stb got=%b/%h exp=1/0", wr_stb, wr_addr); end
        n_chk++; if (ctrl_regs !== m_pack()) begin n_fail++; $display("FAIL wrap_reg0 got=%h exp=%h", ctrl_regs, m_pack()); end
        end_frame();
        n_chk++; if (stb_q.size() != 1) begin n_fail++; $display("FAIL wrap_stb_count got=%0d exp=1", stb_q.size()); end
        start_frame();
        send_rx(8'h88, 1'b0);
        n_chk++; if (bus.tx_data !== 8'h5A) begin n_fail++; $display("FAIL status0 got=%h exp=5a", bus.tx_data); end
        end_frame();
        start_frame();
        send_rx(8'h8F, 1'b0);
        exp = m_read(15);
        n_chk++; if (bus.tx_data !== exp) begin n_fail++; $display("FAIL status7 got=%h exp=%h", bus.tx_data, exp); end
        send_rx(8'h00, 1'b1);
        n_chk++; if (bus.tx_data !== 8'h22) begin n_fail++; $display("FAIL rd_wrap got=%h exp=22", bus.tx_data); end
        end_frame();
    endtask

    task automatic test_reserved();
        stb_q.delete();
        start_frame();
        send_rx(8'h40, 1'b0);
        m_err = 1'b1;
        send_rx(8'h12, 1'b1);
        send_rx(8'h34, 1'b1);
        n_chk++; if (bus.tx_call !== 1'b0) begin n_fail++; $display("FAIL rsv_tx_call got=%b exp=0", bus.tx_call); end
        n_chk++; if (ctrl_regs !== m_pack()) begin n_fail++; $display("FAIL rsv_regs got=%h exp=%h", ctrl_regs, m_pack()); end
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL rsv_err got=%b exp=1", err); end
        end_frame();
        n_chk++; if (stb_q.size() != 0) begin n_fail++; $display("FAIL rsv_stb_count got=%0d exp=0", stb_q.size()); end
        start_frame();
        send_rx(8'h00, 1'b0);
        send_rx(8'h80, 1'b0);
        m_write(0, 8'h80);
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear got=%b exp=0", err); end
        n_chk++; if (ctrl_regs[7:0] !== 8'h00) begin n_fail++; $display("FAIL reg0_bit7 got=%h exp=00", ctrl_regs[7:0]); end
        end_frame();
    endtask

    task automatic test_partial_frame();
        logic [7:0] exp;
        stb_q.delete();
        start_frame();
        send_rx(8'h01, 1'b0);
        repeat (5) cyc();
        bus.cs_n = 1'b1;
        cyc();
        n_chk++; if (bus.tx_call !== 1'b0) begin n_fail++; $display("FAIL part_tx_call got=%b exp=0", bus.tx_call); end
        n_chk++; if (ctrl_regs !== m_pack()) begin n_fail++; $display("FAIL part_regs got=%h exp=%h", ctrl_regs, m_pack()); end
        send_rx(8'h55, 1'b0);
        n_chk++; if (wr_stb !== 1'b0 || ctrl_regs !== m_pack()) begin n_fail++; $display("FAIL idle_rx got=%b/%h exp=0/%h", wr_stb, ctrl_regs, m_pack()); end
        cyc();
        n_chk++; if (stb_q.size() != 0) begin n_fail++; $display("FAIL part_stb_count got=%0d exp=0", stb_q.size()); end
        start_frame();
        send_rx(8'h81, 1'b0);
        exp = m_read(1);
        n_chk++; if (bus.tx_call !== 1'b1 || bus.tx_data !== exp) begin n_fail++; $display("FAIL part_next_cmd got=%b/%h exp=1/%h", bus.tx_call, bus.tx_data, exp); end
        end_frame();
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] exp;
        start_frame();
        send_rx(8'h83, 1'b0);
        send_rx(8'h00, 1'b1);
        exp = m_read(4);
        n_chk++; if (bus.tx_data !== exp) begin n_fail++; $display("FAIL rmr_pre got=%h exp=%h", bus.tx_data, exp); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        m_reset();
        n_chk++; if (bus.tx_call !== 1'b0) begin n_fail++; $display("FAIL rmr_tx_call got=%b exp=0", bus.tx_call); end
        n_chk++; if (ctrl_regs !== m_pack() || err !== 1'b0) begin n_fail++; $display("FAIL rmr_state got=%h/%b exp=%h/0", ctrl_regs, err, m_pack()); end
        stb_q.delete();
        repeat (3) cyc();
        send_rx(8'h05, 1'b0);
        send_rx(8'h77, 1'b0);
        send_rx(8'h83, 1'b0);
        n_chk++; if (bus.tx_call !== 1'b0) begin n_fail++; $display("FAIL rmr_ignore_rd got=%b exp=0", bus.tx_call); end
        cyc();
        n_chk++; if (stb_q.size() != 0 || ctrl_regs !== m_pack()) begin n_fail++; $display("FAIL rmr_ignore_wr got=%0d/%h exp=0/%h", stb_q.size(), ctrl_regs, m_pack()); end
        end_frame();
        start_frame();
        send_rx(8'h83, 1'b0);
        exp = m_read(3);
        n_chk++; if (bus.tx_call !== 1'b1 || bus.tx_data !== exp) begin n_fail++; $display("FAIL rmr_resume got=%b/%h exp=1/%h", bus.tx_call, bus.tx_data, exp); end
        end_frame();
    endtask

    task automatic test_back_to_back();
        stb_q.delete();
        start_frame();
        send_rx(8'h06, 1'b0);
        send_rx(8'h61, 1'b0); m_write(6, 8'h61);
        send_rx(8'h62, 1'b0); m_write(7, 8'h62);
        n_chk++; if (wr_stb !== 1'b1 || wr_addr !== 4'd7) begin n_fail++; $display("FAIL b2b_stb got=%b/%h exp=1/7", wr_stb, wr_addr); end
        send_rx(8'h63, 1'b0); m_write(8, 8'h63);
        n_chk++; if (ctrl_regs !== m_pack() || err !== m_err) begin n_fail++; $display("FAIL b2b_regs got=%h/%b exp=%h/%b", ctrl_regs, err, m_pack(), m_err); end
        end_frame();
        n_chk++; if (stb_q.size() != 2) begin n_fail++; $display("FAIL b2b_stb_count got=%0d exp=2", stb_q.size()); end
    endtask

    task automatic test_random();
        logic       is_rd;
        logic [3:0] ap;
        logic [7:0] d, exp;
        logic       exp_stb;
        int         len;
        for (int f = 0; f < 30; f++) begin
            is_rd = 1'($urandom_range(0, 1));
            ap    = 4'($urandom_range(0, 15));
            len   = $urandom_range(1, 5);
            status_in = {$urandom, $urandom};
            start_frame();
            send_rx({is_rd, 3'b000, ap}, 1'b0);
            if (is_rd) begin
                exp = m_read(int'(ap));
                n_chk++; if (bus.tx_call !== 1'b1 || bus.tx_data !== exp) begin n_fail++; $display("FAIL rnd_rd_first f=%0d got=%b/%h exp=1/%h", f, bus.tx_call, bus.tx_data, exp); end
                for (int k = 0; k < len; k++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        status_in = {$urandom, $urandom};
                        cyc();
                        n_chk++; if (bus.tx_data !== exp) begin n_fail++; $display("FAIL rnd_rd_inflight f=%0d got=%h exp=%h", f, bus.tx_data, exp); end
                    end
                    repeat ($urandom_range(0, 2)) cyc();
                    send_rx(8'($urandom), 1'b1);
                    ap  = ap + 4'd1;
                    exp = m_read(int'(ap));
                    n_chk++; if (bus.tx_data !== exp) begin n_fail++; $display("FAIL rnd_rd f=%0d a=%0d got=%h exp=%h", f, ap, bus.tx_data, exp); end
                end
            end else begin
                for (int k = 0; k < len; k++) begin
                    d = 8'($urandom);
                    repeat ($urandom_range(0, 2)) cyc();
                    send_rx(d, 1'($urandom_range(0, 1)));
                    exp_stb = (ap < 4'd8);
                    m_write(int'(ap), d);
                    n_chk++; if (wr_stb !== exp_stb || (exp_stb && wr_addr !== ap)) begin n_fail++; $display("FAIL rnd_wr_stb f=%0d got=%b/%h exp=%b/%h", f, wr_stb, wr_addr, exp_stb, ap); end
                    n_chk++; if (ctrl_regs !== m_pack() || err !== m_err) begin n_fail++; $display("FAIL rnd_wr f=%0d got=%h/%b exp=%h/%b", f, ctrl_regs, err, m_pack(), m_err); end
                    ap = ap + 4'd1;
                end
            end
            bus.cs_n = 1'b1;
            cyc();
            n_chk++; if (bus.tx_call !== 1'b0) begin n_fail++; $display("FAIL rnd_end f=%0d got=%b exp=0", f, bus.tx_call); end
            cyc();
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.cs_n    = 1'b1;
        bus.rx_data = 8'h00;
        bus.rx_done = 1'b0;
        bus.tx_done = 1'b0;
        status_in   = 64'h0;
        test_reset();
        test_read_burst();
        test_write_burst();
        test_wrap_ro();
        test_reserved();
        test_partial_frame();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
